// File: rtl/loader_pkg.sv
// Shared types and constants for the serial program loader and its helpers.
// The CHECK state and checksum frame length apply only with PROGRAM_LOADER_CHECKSUM_EN.
package loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      DATA,
      CHECK,
      WRITE,
      DONE
   } loader_state_t;

   localparam logic [7:0] LOADER_HDR_INSTR = 8'hA5;
   localparam logic [7:0] LOADER_HDR_DATA  = 8'h5A;
   localparam logic [7:0] LOADER_HDR_RUN   = 8'hFF;

   // Frame = header + address byte + word bytes (+ optional checksum byte).
   localparam int WORD_BYTES         = 4;
   localparam int FRAME_LEN_BASE     = 2 + WORD_BYTES;
   localparam int FRAME_LEN_CHECKSUM = FRAME_LEN_BASE + 1;

endpackage

// File: rtl/byte_assembler.sv
// Big-endian byte-to-word shift register with a byte counter.
// done is high on the shift that completes a word; next_word is the word that shift stores.
module byte_assembler
   import loader_pkg::*;
(
   input  logic                      clk,
   input  logic                      resetN,
   input  logic                      clear,
   input  logic                      shift,
   input  logic [7:0]                byteIn,
   output logic [8*WORD_BYTES-1:0]   word,
   output logic [8*WORD_BYTES-1:0]   next_word,
   output logic                      done
);

   localparam int CW = $clog2(WORD_BYTES);

   logic [CW-1:0] count;

   assign next_word = {word[8*WORD_BYTES-9:0], byteIn};
   assign done      = shift && (count == CW'(WORD_BYTES - 1));

   always_ff @(posedge clk) begin
      if (!resetN) begin
         word  <= '0;
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (shift) begin
         word  <= next_word;
         count <= done ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/program_loader.sv
// Boot loader: parses header/address/data byte frames and drives the core's memory load ports.
// Define PROGRAM_LOADER_CHECKSUM_EN for 7-byte frames with an XOR checksum and a checksumError output.
module program_loader
   import loader_pkg::*;
#(
   parameter int         ADDR_WIDTH = 7,
   parameter int         DATA_WIDTH = 32,
   parameter logic [7:0] HDR_INSTR  = LOADER_HDR_INSTR,
   parameter logic [7:0] HDR_DATA   = LOADER_HDR_DATA,
   parameter logic [7:0] HDR_RUN    = LOADER_HDR_RUN
) (
   input  logic                  clk,
   input  logic                  resetN,
   input  logic [7:0]            byteIn,
   input  logic                  byteValid,
   output logic                  byteReady,
   output logic [DATA_WIDTH-1:0] instruction,
   output logic [ADDR_WIDTH-1:0] instructionAddress,
   output logic                  instrWriteEnable,
   output logic [DATA_WIDTH-1:0] data,
   output logic [ADDR_WIDTH-1:0] dataAddress,
   output logic                  dataWriteEnable,
   output logic                  cpuRun,
   output logic                  badHeader
`ifdef PROGRAM_LOADER_CHECKSUM_EN
   ,
   output logic                  checksumError
`endif
);

   loader_state_t         state;
   logic                  target_instr;
   logic [ADDR_WIDTH-1:0] addr_reg;
   logic                  accept;
   logic                  asm_done;
   logic                  write_go;
   logic [DATA_WIDTH-1:0] asm_word;
   logic [DATA_WIDTH-1:0] asm_next;
   logic [DATA_WIDTH-1:0] word_to_write;

   assign accept = byteValid && byteReady;

   byte_assembler u_assembler (
      .clk       (clk),
      .resetN    (resetN),
      .clear     ((state == ADDR) && accept),
      .shift     ((state == DATA) && accept),
      .byteIn    (byteIn),
      .word      (asm_word),
      .next_word (asm_next),
      .done      (asm_done)
   );

   // Without a checksum the write fires on the last data byte, so the word is taken pre-register.
   assign word_to_write = (state == DATA) ? asm_next : asm_word;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic [7:0] checksum_reg;
   assign write_go = (state == CHECK) && accept && ((checksum_reg ^ byteIn) == 8'h00);
`else
   assign write_go = asm_done;
`endif

   always_ff @(posedge clk) begin
      if (!resetN) begin
         state              <= IDLE;
         byteReady          <= 1'b1;
         instruction        <= '0;
         instructionAddress <= '0;
         instrWriteEnable   <= 1'b0;
         data               <= '0;
         dataAddress        <= '0;
         dataWriteEnable    <= 1'b0;
         cpuRun             <= 1'b0;
         badHeader          <= 1'b0;
         target_instr       <= 1'b0;
         addr_reg           <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         checksum_reg       <= 8'h00;
         checksumError      <= 1'b0;
`endif
      end else begin
         instrWriteEnable <= 1'b0;
         dataWriteEnable  <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (byteIn == HDR_INSTR) begin
                     target_instr <= 1'b1;
                     state        <= ADDR;
                  end else if (byteIn == HDR_DATA) begin
                     target_instr <= 1'b0;
                     state        <= ADDR;
                  end else if (byteIn == HDR_RUN) begin
                     state     <= DONE;
                     byteReady <= 1'b0;
                     cpuRun    <= 1'b1;
                  end else begin
                     badHeader <= 1'b1;
                  end
               end
            end
            ADDR: begin
               if (accept) begin
                  addr_reg <= byteIn[ADDR_WIDTH-1:0];
                  state    <= DATA;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                  checksum_reg <= byteIn;
`endif
               end
            end
            DATA: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
               if (accept) begin
                  checksum_reg <= checksum_reg ^ byteIn;
               end
               if (asm_done) begin
                  state <= CHECK;
               end
`endif
            end
            CHECK: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
               if (accept && !write_go) begin
                  checksumError <= 1'b1;
                  state         <= IDLE;
               end
`endif
            end
            WRITE: begin
               state     <= IDLE;
               byteReady <= 1'b1;
            end
            DONE: begin
               cpuRun    <= 1'b1;
               byteReady <= 1'b0;
            end
            default: state <= IDLE;
         endcase

         if (write_go) begin
            state     <= WRITE;
            byteReady <= 1'b0;
            if (target_instr) begin
               instruction        <= word_to_write;
               instructionAddress <= addr_reg;
               instrWriteEnable   <= 1'b1;
            end else begin
               data            <= word_to_write;
               dataAddress     <= addr_reg;
               dataWriteEnable <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: table-driven frames plus hand-written corner sequences,
// with a write scoreboard checked by a strobe monitor.
module tb_program_loader;
   import loader_pkg::*;

   logic        clk;
   logic        resetN;
   logic [7:0]  byteIn;
   logic        byteValid;
   logic        byteReady;
   logic [31:0] instruction;
   logic [6:0]  instructionAddress;
   logic        instrWriteEnable;
   logic [31:0] data;
   logic [6:0]  dataAddress;
   logic        dataWriteEnable;
   logic        cpuRun;
   logic        badHeader;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic        checksumError;
   localparam int NBYTES = FRAME_LEN_CHECKSUM;
`else
   localparam int NBYTES = FRAME_LEN_BASE;
`endif

   program_loader dut (
      .clk                (clk),
      .resetN             (resetN),
      .byteIn             (byteIn),
      .byteValid          (byteValid),
      .byteReady          (byteReady),
      .instruction        (instruction),
      .instructionAddress (instructionAddress),
      .instrWriteEnable   (instrWriteEnable),
      .data               (data),
      .dataAddress        (dataAddress),
      .dataWriteEnable    (dataWriteEnable),
      .cpuRun             (cpuRun),
      .badHeader          (badHeader)
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      ,
      .checksumError      (checksumError)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       is_instr;
      logic [6:0] addr;
      logic [31:0] word;
   } wr_t;

   typedef struct {
      logic [7:0]  hdr;
      logic [7:0]  ab;
      logic [31:0] w;
      int          maxgap;
      logic        is_instr;
      logic [6:0]  eaddr;
      logic [31:0] eword;
   } vec_t;

   wr_t  sb[$];
   vec_t vecs[4];
   int   checks = 0;
   int   errors = 0;

   logic [31:0] exp_instr, exp_data;
   logic [6:0]  exp_instr_addr, exp_data_addr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] frame_xor(input logic [7:0] ab, input logic [31:0] w);
      return ab ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
   endfunction

   // Strobe monitor: every write strobe must match the oldest expected write.
   always @(negedge clk) begin
      if (resetN) begin
         if (instrWriteEnable || dataWriteEnable) begin
            if (sb.size() == 0) begin
               chk("unexpected_strobe", {30'd0, instrWriteEnable, dataWriteEnable}, 32'd0);
            end else begin
               wr_t e;
               e = sb.pop_front();
               chk("instr_we", {31'd0, instrWriteEnable}, {31'd0, e.is_instr});
               chk("data_we", {31'd0, dataWriteEnable}, {31'd0, !e.is_instr});
               chk("write_addr", {25'd0, e.is_instr ? instructionAddress : dataAddress}, {25'd0, e.addr});
               chk("write_word", e.is_instr ? instruction : data, e.word);
               $display("write %s addr=%h word=%h", e.is_instr ? "instr" : "data ",
                        e.is_instr ? instructionAddress : dataAddress,
                        e.is_instr ? instruction : data);
            end
         end
         if (!cpuRun) begin
            chk("ready_low_only_in_write", {31'd0, byteReady},
                {31'd0, !(instrWriteEnable || dataWriteEnable)});
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap);
      int waited;
      byteValid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      byteIn    = b;
      byteValid = 1'b1;
      waited    = 0;
      while (!byteReady && waited < 50) begin
         @(posedge clk); #1;
         waited++;
      end
      chk("byte_accept", {31'd0, byteReady}, 32'd1);
      if (byteReady) begin
         @(posedge clk); #1;
      end
      byteValid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] hdr, input logic [7:0] ab, input logic [31:0] w,
                             input int maxgap, input logic expect_write, input logic is_instr,
                             input logic [6:0] eaddr, input logic [31:0] eword,
                             input logic [7:0] cks);
      logic [7:0] fb[7];
      wr_t e;
      fb[0] = hdr;     fb[1] = ab;
      fb[2] = w[31:24]; fb[3] = w[23:16]; fb[4] = w[15:8]; fb[5] = w[7:0];
      fb[6] = cks;
      for (int i = 0; i < NBYTES; i++) begin
         if (i == NBYTES - 1 && expect_write) begin
            e.is_instr = is_instr; e.addr = eaddr; e.word = eword;
            sb.push_back(e);
         end
         send_byte(fb[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
      end
      if (expect_write) begin
         chk("strobe_latency", {31'd0, is_instr ? instrWriteEnable : dataWriteEnable}, 32'd1);
         chk("other_strobe_low", {31'd0, is_instr ? dataWriteEnable : instrWriteEnable}, 32'd0);
         chk("ready_low_in_write", {31'd0, byteReady}, 32'd0);
         if (is_instr) begin exp_instr = eword; exp_instr_addr = eaddr; end
         else          begin exp_data  = eword; exp_data_addr  = eaddr; end
      end else begin
         chk("no_strobe", {30'd0, instrWriteEnable, dataWriteEnable}, 32'd0);
      end
   endtask

   task automatic check_buses();
      chk("instr_hold", instruction, exp_instr);
      chk("instr_addr_hold", {25'd0, instructionAddress}, {25'd0, exp_instr_addr});
      chk("data_hold", data, exp_data);
      chk("data_addr_hold", {25'd0, dataAddress}, {25'd0, exp_data_addr});
   endtask

   task automatic check_reset_values();
      chk("rst_byteReady", {31'd0, byteReady}, 32'd1);
      chk("rst_instrWE", {31'd0, instrWriteEnable}, 32'd0);
      chk("rst_dataWE", {31'd0, dataWriteEnable}, 32'd0);
      chk("rst_cpuRun", {31'd0, cpuRun}, 32'd0);
      chk("rst_badHeader", {31'd0, badHeader}, 32'd0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      chk("rst_checksumError", {31'd0, checksumError}, 32'd0);
`endif
      exp_instr = '0; exp_instr_addr = '0; exp_data = '0; exp_data_addr = '0;
      check_buses();
   endtask

   initial begin
      vecs[0] = '{8'hA5, 8'h00, 32'h20220002, 0, 1'b1, 7'h00, 32'h20220002};
      vecs[1] = '{8'h5A, 8'h01, 32'h00000002, 0, 1'b0, 7'h01, 32'h00000002};
      vecs[2] = '{8'h5A, 8'h85, 32'hDEADBEEF, 5, 1'b0, 7'h05, 32'hDEADBEEF};
      vecs[3] = '{8'hA5, 8'hFF, 32'h12345678, 2, 1'b1, 7'h7F, 32'h12345678};

      resetN    = 1'b0;
      byteValid = 1'b0;
      byteIn    = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check_reset_values();
      resetN = 1'b1;

      for (int i = 0; i < 4; i++) begin
         send_frame(vecs[i].hdr, vecs[i].ab, vecs[i].w, vecs[i].maxgap, 1'b1, vecs[i].is_instr,
                    vecs[i].eaddr, vecs[i].eword, frame_xor(vecs[i].ab, vecs[i].w));
         repeat (2) begin @(posedge clk); #1; end
         check_buses();
      end
      chk("badHeader_clear", {31'd0, badHeader}, 32'd0);

      // Unknown header: consumed, flagged, no write, still ready.
      send_byte(8'h33, 0);
      chk("badHeader_set", {31'd0, badHeader}, 32'd1);
      chk("badHeader_ready", {31'd0, byteReady}, 32'd1);
      repeat (2) begin @(posedge clk); #1; end
      check_buses();

      // Reset in the middle of a frame discards it.
      send_byte(8'hA5, 0);
      send_byte(8'h10, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      resetN = 1'b0;
      @(posedge clk); #1;
      check_reset_values();
      resetN = 1'b1;
      send_frame(8'hA5, 8'h02, 32'h00000007, 0, 1'b1, 1'b1, 7'h02, 32'h00000007,
                 frame_xor(8'h02, 32'h00000007));
      repeat (2) begin @(posedge clk); #1; end
      check_buses();

`ifdef PROGRAM_LOADER_CHECKSUM_EN
      send_frame(8'hA5, 8'h03, 32'h00000001, 0, 1'b1, 1'b1, 7'h03, 32'h00000001, 8'h02);
      repeat (2) begin @(posedge clk); #1; end
      chk("cks_ok_no_error", {31'd0, checksumError}, 32'd0);
      send_frame(8'hA5, 8'h03, 32'h00000001, 0, 1'b0, 1'b1, 7'h03, 32'h00000001, 8'h00);
      repeat (2) begin @(posedge clk); #1; end
      chk("cks_bad_error", {31'd0, checksumError}, 32'd1);
      check_buses();
`endif

      // Run command, then further bytes must be ignored.
      send_byte(8'hFF, 0);
      chk("run_cpuRun", {31'd0, cpuRun}, 32'd1);
      chk("run_ready", {31'd0, byteReady}, 32'd0);
      byteValid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         byteIn = (i % 2 == 0) ? 8'hA5 : 8'h5A;
         @(posedge clk); #1;
      end
      byteValid = 1'b0;
      chk("done_cpuRun_held", {31'd0, cpuRun}, 32'd1);
      chk("done_ready_held", {31'd0, byteReady}, 32'd0);
      check_buses();

      // Reset while running drops cpuRun on the same edge.
      resetN = 1'b0;
      @(posedge clk); #1;
      chk("done_reset_cpuRun", {31'd0, cpuRun}, 32'd0);
      chk("done_reset_ready", {31'd0, byteReady}, 32'd1);
      resetN = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      chk("scoreboard_empty", sb.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Upstream boot stage for the MIPS core (`main`).
- Receives a byte stream, for example from a UART receiver, and assembles 32-bit words.
- Drives the core's instruction-memory and data-memory load ports (word plus 7-bit address plus write strobe).
- After the run command it releases the core by asserting cpuRun.

Parameters:
ADDR_WIDTH, 7, memory word-address width for both instruction and data memories
DATA_WIDTH, 32, word width; must be 32 (4 bytes per word)
HDR_INSTR, 8'hA5, header byte selecting an instruction-memory write
HDR_DATA, 8'h5A, header byte selecting a data-memory write
HDR_RUN, 8'hFF, header byte ending the load and starting the core

Ports:
clk  input  1  system clock; all logic on rising edge
resetN  input  1  synchronous active-low reset
byteIn  input  8  incoming stream byte
byteValid  input  1  byteIn valid this cycle
byteReady  output  1  loader can accept a byte this cycle
instruction  output  32  word for instruction memory
instructionAddress  output  7  instruction memory word address
instrWriteEnable  output  1  one-cycle instruction-memory write strobe
data  output  32  word for data memory
dataAddress  output  7  data memory word address
dataWriteEnable  output  1  one-cycle data-memory write strobe
cpuRun  output  1  core may execute; held low during loading
badHeader  output  1  sticky: an unknown header byte was received

Behaviour:
- Interface: one clock (clk); reset resetN is synchronous and active-low, sampled on the rising clk edge.
- Reset values: all outputs 0 except byteReady=1; state=IDLE; byte counter=0; assembly register=0.
- Handshake: a byte is accepted on a rising edge where byteValid && byteReady; byteIn must be stable while byteValid=1.
- Frame format: header, address byte, then 4 data bytes, MSB first (big-endian).
- Address: taken from addrByte[6:0]; bit 7 is ignored.
- IDLE:
  - Accepted HDR_INSTR or HDR_DATA: latch target, go to ADDR.
  - Accepted HDR_RUN: go to DONE.
  - Any other byte: set badHeader, stay in IDLE. The byte is still consumed.
- ADDR: accepted byte latches the address; counter=0; go to DATA.
- DATA: each accepted byte shifts into the assembly register (word = {word[23:0], byteIn}); counter increments. On the 4th byte go to WRITE.
- WRITE (exactly one cycle, byteReady=0):
  - Drive the selected bus (instruction/instructionAddress or data/dataAddress) with the assembled word and address.
  - Pulse the matching write enable high for this cycle only, then return to IDLE.
- Latency: the strobe is high in the cycle immediately after the edge that accepted the 4th data byte.
- Bus hold: data/address buses hold their last written value until the next write to the same target; the other target's bus is unchanged.
- DONE: cpuRun=1, byteReady=0; terminal until reset; byteValid is ignored.
- Reset mid-frame: the partial frame is discarded, no strobe is issued, and outputs return to reset values.
- Reset while in DONE: cpuRun drops to 0 on the same edge.
- byteValid low between bytes of a frame: stall in the current state indefinitely; there is no timeout.
- badHeader clears only on reset.

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN.
- Defined:
  - Each instruction/data frame carries a 7th byte: the XOR of the address byte and the 4 data bytes. A new CHECK state accepts it.
  - Match: proceed to WRITE.
  - Mismatch: no strobe; set a sticky output checksumError (1 bit, reset 0); return to IDLE.
- Not defined: 6-byte frames, no CHECK state, no checksumError port.

Decomposition:
- Shared package loader_pkg holds:
  - the state enum (IDLE, ADDR, DATA, CHECK, WRITE, DONE);
  - the header constants;
  - the frame length constants.
- One natural sub-module, byte_assembler: 4-byte shift register with counter and done flag, reusable by other serial loaders.

Test Plan:
- Instruction write: send A5 00 20 22 00 02 -> one cycle after the last byte, instruction=32'h20220002, instructionAddress=0, instrWriteEnable=1 for exactly one cycle; dataWriteEnable stays 0.
- Data write: send 5A 01 00 00 00 02 -> data=32'd2, dataAddress=7'd1, dataWriteEnable single-cycle pulse; the instruction bus still holds 32'h20220002.
- Address masking and stalls: send 5A 85 DE AD BE EF with byteValid gaps of 0-5 cycles -> dataAddress=7'h05, data=32'hDEADBEEF, exactly one strobe; byteReady=0 only in the WRITE cycle.
- Bad header then run: send 33 -> badHeader=1, state IDLE, no strobe; then send FF -> cpuRun=1, byteReady=0; further bytes have no effect.
- Reset mid-frame: send A5 10 11 22, pull resetN low for one cycle, then send A5 02 00 00 00 07 -> a single write of 32'h00000007 to address 2; the first frame never strobes.
- With PROGRAM_LOADER_CHECKSUM_EN:
  - A5 03 00 00 00 01 02 is written (checksum 03^01=02).
  - A5 03 00 00 00 01 00 causes no strobe and sets checksumError=1.
